// File: rtl/wb_din_stage_pkg.sv
// Shared definitions for the register-file write-back stage:
// din source encodings, FSM state type and the x0 write-suppression helper.
package wb_din_stage_pkg;

   // din source select encodings (CTL values)
   localparam int unsigned DIN_SRC_PC   = 0;
   localparam int unsigned DIN_SRC_MM   = 1;
   localparam int unsigned DIN_SRC_ALU  = 2;
   localparam int unsigned DIN_SRC_INST = 3;

   typedef enum logic [0:0] {
      WB_IDLE    = 1'b0,
      WB_WAIT_MM = 1'b1
   } wb_state_t;

   // A write is allowed unless the target is x0 and x0 is read-only
   function automatic logic wr_allowed(input logic zero_ro, input logic addr_is_zero);
      return !(zero_ro && addr_is_zero);
   endfunction

endpackage

// File: rtl/wb_src_sel.sv
// Parametrised NSRC:1 write-data source mux. Any CTL value at or above NSRC
// selects the last source, matching the legacy mux default branch.
module wb_src_sel #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NSRC   = 4,
   parameter int unsigned SEL_W  = 2
) (
   input  logic [SEL_W-1:0]       CTL,
   input  logic [NSRC*DATA_W-1:0] SRC,
   output logic [DATA_W-1:0]      DOUT
);

   // Default to the last source so out-of-range selects clamp to it
   always_comb begin
      DOUT = SRC[(NSRC-1)*DATA_W +: DATA_W];
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (32'(CTL) == i) DOUT = SRC[i*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/wb_din_stage.sv
// Registered write-back stage: picks the register-file write data from the
// din sources, handshakes requests, waits on the memory source with a
// timeout, and supports flush and x0 write suppression.
module wb_din_stage
   import wb_din_stage_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NSRC    = 4,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned MEM_SRC = DIN_SRC_MM,
   parameter int unsigned TIMEOUT = 15,
   parameter bit          ZERO_RO = 1'b1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [SEL_W-1:0]       CTL,
   input  logic [ADDR_W-1:0]      WADDR,
   input  logic [NSRC*DATA_W-1:0] SRC,
   input  logic                   MM_VALID,
   input  logic                   FLUSH,
   output logic                   WE,
   output logic [ADDR_W-1:0]      WA,
   output logic [DATA_W-1:0]      WD,
   output logic                   BUSY,
   output logic                   ERR
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   wb_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] mm_data;
   logic              accept;
   logic              is_mem;

   wb_src_sel #(
      .DATA_W (DATA_W),
      .NSRC   (NSRC),
      .SEL_W  (SEL_W)
   ) u_src_sel (
      .CTL  (CTL),
      .SRC  (SRC),
      .DOUT (sel_data)
   );

   assign mm_data  = SRC[MEM_SRC*DATA_W +: DATA_W];
   assign IN_READY = (state == WB_IDLE) && !RST;
   assign BUSY     = (state == WB_WAIT_MM);
   assign accept   = IN_VALID && IN_READY && !FLUSH;
   assign is_mem   = (CTL == SEL_W'(MEM_SRC));

   // FSM, timeout counter and registered write-port outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= WB_IDLE;
         cnt     <= '0;
         waddr_q <= '0;
         WE      <= 1'b0;
         WA      <= '0;
         WD      <= '0;
         ERR     <= 1'b0;
      end else begin
         WE  <= 1'b0;
         ERR <= 1'b0;
         case (state)
            WB_IDLE: begin
               if (accept) begin
                  if (is_mem && !MM_VALID) begin
                     state   <= WB_WAIT_MM;
                     waddr_q <= WADDR;
                     cnt     <= '0;
                  end else if (wr_allowed(ZERO_RO, WADDR == '0)) begin
                     WE <= 1'b1;
                     WA <= WADDR;
                     WD <= sel_data;
                  end
               end
            end
            WB_WAIT_MM: begin
               if (FLUSH) begin
                  state <= WB_IDLE;
               end else if (MM_VALID) begin
                  state <= WB_IDLE;
                  if (wr_allowed(ZERO_RO, waddr_q == '0)) begin
                     WE <= 1'b1;
                     WA <= waddr_q;
                     WD <= mm_data;
                  end
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state <= WB_IDLE;
                  ERR   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

endmodule
